// File: rtl/fmrv32im_axis_sram_pkg.sv
// fmrv32im_axis_sram_pkg: shared FSM state and AXI encodings for the burst SRAM slave.
package fmrv32im_axis_sram_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_WDATA, ST_WRESP, ST_RDATA} state_t;

    typedef enum logic [1:0] {BURST_FIXED = 2'b00, BURST_INCR = 2'b01, BURST_WRAP = 2'b10, BURST_RSVD = 2'b11} burst_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [2:0] SIZE_WORD   = 3'b010;

    function automatic logic req_err(input logic [2:0] size, input logic [1:0] burst);
        return size != SIZE_WORD || burst == BURST_RSVD;
    endfunction

endpackage

// File: rtl/fmrv32im_sram_1p.sv
// fmrv32im_sram_1p: single-port word RAM with byte write enables and a registered read
module fmrv32im_sram_1p #(
  parameter int ADDR_WIDTH = 14,
  parameter     MEM_FILE   = ""
) (
  input  logic                  i_clk,
  input  logic                  i_en,
  input  logic [3:0]            i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata
);
  logic [31:0] r_mem [0:(1<<ADDR_WIDTH)-1];
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++)
      if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    if (i_en) o_rdata <= r_mem[i_addr];
  end
endmodule

// File: rtl/fmrv32im_axis_sram.sv
// fmrv32im_axis_sram: AXI4 burst slave serving one write or read burst at a time from a
// single-port SRAM; reads flow through a 2-entry skid buffer so RREADY stalls lose nothing.
module fmrv32im_axis_sram
    import fmrv32im_axis_sram_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter     MEM_FILE   = ""
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        S_AXI_AWID,
    input  logic [31:0] S_AXI_AWADDR,
    input  logic [7:0]  S_AXI_AWLEN,
    input  logic [2:0]  S_AXI_AWSIZE,
    input  logic [1:0]  S_AXI_AWBURST,
    input  logic        S_AXI_AWVALID,
    output logic        S_AXI_AWREADY,
    input  logic [31:0] S_AXI_WDATA,
    input  logic [3:0]  S_AXI_WSTRB,
    input  logic        S_AXI_WLAST,
    input  logic        S_AXI_WVALID,
    output logic        S_AXI_WREADY,
    output logic        S_AXI_BID,
    output logic [1:0]  S_AXI_BRESP,
    output logic        S_AXI_BVALID,
    input  logic        S_AXI_BREADY,
    input  logic        S_AXI_ARID,
    input  logic [31:0] S_AXI_ARADDR,
    input  logic [7:0]  S_AXI_ARLEN,
    input  logic [2:0]  S_AXI_ARSIZE,
    input  logic [1:0]  S_AXI_ARBURST,
    input  logic        S_AXI_ARVALID,
    output logic        S_AXI_ARREADY,
    output logic        S_AXI_RID,
    output logic [31:0] S_AXI_RDATA,
    output logic [1:0]  S_AXI_RRESP,
    output logic        S_AXI_RLAST,
    output logic        S_AXI_RVALID,
    input  logic        S_AXI_RREADY
);

    state_t                r_state, w_next;
    logic                  r_awready, r_arready, r_last_rd, r_err, r_id, r_pend;
    logic [7:0]            r_len, r_beat;
    logic [1:0]            r_burst, r_qcnt, w_qbase;
    logic [8:0]            r_issued;
    logic [ADDR_WIDTH-1:0] r_addr, w_aw_word, w_ar_word, w_ram_addr;
    logic [31:0]           r_q0, r_q1, w_ram_rdata, w_push;
    logic [3:0]            w_ram_we;
    logic                  w_aw_hs, w_ar_hs, w_w_hs, w_w_end, w_rvalid, w_pop, w_last_beat;
    logic                  w_arb, w_gnt_r, w_gnt_w, w_rd_issue, w_unused;

    function automatic logic [ADDR_WIDTH-1:0] step(input logic [ADDR_WIDTH-1:0] a, input logic [1:0] b);
        return (b == BURST_INCR || b == BURST_WRAP) ? a + ADDR_WIDTH'(1) : a;
    endfunction

    assign w_unused    = ^{S_AXI_AWADDR[31:ADDR_WIDTH+2], S_AXI_AWADDR[1:0],
                           S_AXI_ARADDR[31:ADDR_WIDTH+2], S_AXI_ARADDR[1:0]};
    assign w_aw_word   = S_AXI_AWADDR[ADDR_WIDTH+1:2];
    assign w_ar_word   = S_AXI_ARADDR[ADDR_WIDTH+1:2];
    assign w_aw_hs     = S_AXI_AWVALID & r_awready;
    assign w_ar_hs     = S_AXI_ARVALID & r_arready;
    assign w_w_hs      = (r_state == ST_WDATA) & S_AXI_WVALID;
    assign w_last_beat = r_beat == r_len;
    assign w_w_end     = w_w_hs & (S_AXI_WLAST | w_last_beat);
    assign w_rvalid    = r_qcnt != 2'd0;
    assign w_pop       = w_rvalid & S_AXI_RREADY;
    assign w_qbase     = r_qcnt - {1'b0, w_pop};
    assign w_arb       = (r_state == ST_IDLE) & ~r_awready & ~r_arready;
    assign w_gnt_r     = S_AXI_ARVALID & (~S_AXI_AWVALID | ~r_last_rd);
    assign w_gnt_w     = S_AXI_AWVALID & ~w_gnt_r;
    // First read goes out on the AR handshake itself; later ones only if the buffer can absorb them.
    assign w_rd_issue  = w_ar_hs | ((r_state == ST_RDATA) & (r_issued <= {1'b0, r_len}) &
                                    ((w_qbase + {1'b0, r_pend}) < 2'd2));
    assign w_ram_addr  = w_ar_hs ? w_ar_word : r_addr;
    assign w_ram_we    = (w_w_hs & ~r_err) ? S_AXI_WSTRB : 4'h0;
    assign w_push      = r_err ? 32'h0 : w_ram_rdata;

    fmrv32im_sram_1p #(.ADDR_WIDTH(ADDR_WIDTH), .MEM_FILE(MEM_FILE)) u_sram (
        .i_clk  (CLK),
        .i_en   (w_rd_issue),
        .i_we   (w_ram_we),
        .i_addr (w_ram_addr),
        .i_wdata(S_AXI_WDATA),
        .o_rdata(w_ram_rdata)
    );

    always_ff @(posedge CLK) begin
        if (RST) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  w_next = w_aw_hs ? ST_WDATA : w_ar_hs ? ST_RDATA : ST_IDLE;
            ST_WDATA: w_next = w_w_end ? ST_WRESP : ST_WDATA;
            ST_WRESP: w_next = S_AXI_BREADY ? ST_IDLE : ST_WRESP;
            default:  w_next = (w_pop & w_last_beat) ? ST_IDLE : ST_RDATA;
        endcase
    end

    always_comb begin
        S_AXI_AWREADY = r_awready;
        S_AXI_ARREADY = r_arready;
        S_AXI_WREADY  = r_state == ST_WDATA;
        S_AXI_BVALID  = r_state == ST_WRESP;
        S_AXI_BID     = r_id;
        S_AXI_BRESP   = (S_AXI_BVALID & r_err) ? RESP_SLVERR : RESP_OKAY;
        S_AXI_RVALID  = w_rvalid;
        S_AXI_RID     = r_id;
        S_AXI_RDATA   = r_q0;
        S_AXI_RRESP   = (w_rvalid & r_err) ? RESP_SLVERR : RESP_OKAY;
        S_AXI_RLAST   = w_rvalid & w_last_beat;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_awready <= 1'b0;
            r_arready <= 1'b0;
            r_last_rd <= 1'b0;
            r_err     <= 1'b0;
            r_id      <= 1'b0;
            r_pend    <= 1'b0;
            r_len     <= 8'd0;
            r_beat    <= 8'd0;
            r_burst   <= 2'd0;
            r_issued  <= 9'd0;
            r_addr    <= '0;
            r_qcnt    <= 2'd0;
            r_q0      <= 32'h0;
            r_q1      <= 32'h0;
        end else begin
            r_awready <= w_arb & w_gnt_w;
            r_arready <= w_arb & w_gnt_r;
            if (w_arb & (S_AXI_AWVALID | S_AXI_ARVALID)) r_last_rd <= w_gnt_r;
            r_pend <= w_rd_issue;
            if (w_aw_hs) begin
                r_id    <= S_AXI_AWID;
                r_len   <= S_AXI_AWLEN;
                r_burst <= S_AXI_AWBURST;
                r_addr  <= w_aw_word;
                r_beat  <= 8'd0;
                r_err   <= req_err(S_AXI_AWSIZE, S_AXI_AWBURST);
            end else if (w_ar_hs) begin
                r_id     <= S_AXI_ARID;
                r_len    <= S_AXI_ARLEN;
                r_burst  <= S_AXI_ARBURST;
                r_addr   <= step(w_ar_word, S_AXI_ARBURST);
                r_beat   <= 8'd0;
                r_issued <= 9'd1;
                r_err    <= req_err(S_AXI_ARSIZE, S_AXI_ARBURST);
            end else begin
                if (w_w_hs) begin
                    r_addr <= step(r_addr, r_burst);
                    r_beat <= r_beat + 8'd1;
                    if (S_AXI_WLAST & ~w_last_beat) r_err <= 1'b1;
                end
                if (w_rd_issue) begin
                    r_addr   <= step(r_addr, r_burst);
                    r_issued <= r_issued + 9'd1;
                end
                if (w_pop) r_beat <= r_beat + 8'd1;
                if (S_AXI_BVALID & S_AXI_BREADY) r_err <= 1'b0;
            end
            r_q0   <= (r_pend & (w_qbase == 2'd0)) ? w_push : (w_pop ? r_q1 : r_q0);
            r_q1   <= (r_pend & (w_qbase == 2'd1)) ? w_push : r_q1;
            r_qcnt <= w_qbase + {1'b0, r_pend};
        end
    end

endmodule

// File: tb/tb_fmrv32im_axis_sram.sv
// tb_fmrv32im_axis_sram: directed AXI burst transactions against hand-computed expectations.
module tb_fmrv32im_axis_sram;

    logic        CLK = 1'b0, RST = 1'b1;
    logic        S_AXI_AWID = 0, S_AXI_AWVALID = 0, S_AXI_AWREADY;
    logic [31:0] S_AXI_AWADDR = 0;
    logic [7:0]  S_AXI_AWLEN = 0;
    logic [2:0]  S_AXI_AWSIZE = 0;
    logic [1:0]  S_AXI_AWBURST = 0;
    logic [31:0] S_AXI_WDATA = 0;
    logic [3:0]  S_AXI_WSTRB = 0;
    logic        S_AXI_WLAST = 0, S_AXI_WVALID = 0, S_AXI_WREADY;
    logic        S_AXI_BID, S_AXI_BVALID, S_AXI_BREADY = 0;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_ARID = 0, S_AXI_ARVALID = 0, S_AXI_ARREADY;
    logic [31:0] S_AXI_ARADDR = 0;
    logic [7:0]  S_AXI_ARLEN = 0;
    logic [2:0]  S_AXI_ARSIZE = 0;
    logic [1:0]  S_AXI_ARBURST = 0;
    logic        S_AXI_RID, S_AXI_RLAST, S_AXI_RVALID, S_AXI_RREADY = 0;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;

    fmrv32im_axis_sram dut (
        .CLK(CLK), .RST(RST),
        .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
        .S_AXI_AWSIZE(S_AXI_AWSIZE), .S_AXI_AWBURST(S_AXI_AWBURST), .S_AXI_AWVALID(S_AXI_AWVALID),
        .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
        .S_AXI_ARSIZE(S_AXI_ARSIZE), .S_AXI_ARBURST(S_AXI_ARBURST), .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
    );

    always #5 CLK = ~CLK;

    int          n_chk = 0, n_err = 0, n_to = 0;
    logic [31:0] rd_data [0:15];
    logic [1:0]  rd_resp [0:15];
    logic        rd_last [0:15];
    logic        rd_id, rd_extra, b_id;
    logic [1:0]  b_resp;
    int          rd_n, rd_lat, rd_stall_bad, b_wait;
    time         aw_t = 0, ar_t = 0;

    always @(negedge CLK) begin
        if (S_AXI_AWVALID && S_AXI_AWREADY) aw_t = $time;
        if (S_AXI_ARVALID && S_AXI_ARREADY) ar_t = $time;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic id, input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                      input logic [1:0] burst, input logic [31:0] dbase, input int sbeat, input int early);
        int   n;
        logic hs;
        S_AXI_AWID = id; S_AXI_AWADDR = addr; S_AXI_AWLEN = len;
        S_AXI_AWSIZE = size; S_AXI_AWBURST = burst; S_AXI_AWVALID = 1;
        n = 0;
        do begin @(negedge CLK); hs = S_AXI_AWREADY; @(posedge CLK); #1; n++; end while (!hs && n < 100);
        if (!hs) n_to++;
        S_AXI_AWVALID = 0;
        for (int i = 0; i <= int'(len); i++) begin
            if (early >= 0 && i > early) break;
            S_AXI_WDATA  = dbase + 32'(i);
            S_AXI_WSTRB  = (i == sbeat) ? 4'b0011 : 4'hF;
            S_AXI_WLAST  = (i == int'(len)) || (i == early);
            S_AXI_WVALID = 1;
            n = 0;
            do begin @(negedge CLK); hs = S_AXI_WREADY; @(posedge CLK); #1; n++; end while (!hs && n < 100);
            if (!hs) n_to++;
        end
        S_AXI_WVALID = 0; S_AXI_WLAST = 0;
        S_AXI_BREADY = 1;
        b_wait = 0;
        while (1) begin
            @(negedge CLK);
            if (S_AXI_BVALID || b_wait >= 100) break;
            @(posedge CLK); #1; b_wait++;
        end
        if (!S_AXI_BVALID) n_to++;
        b_resp = S_AXI_BRESP; b_id = S_AXI_BID;
        @(posedge CLK); #1;
        S_AXI_BREADY = 0;
    endtask

    // mode 0: RREADY held high; mode 1: RREADY cycles 1,0,0,1. abort_at >= 0 raises RST at that beat.
    task automatic rd(input logic id, input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                      input logic [1:0] burst, input int mode, input int abort_at);
        int          n, k;
        logic        hs, done, stalled;
        logic [35:0] held;
        S_AXI_ARID = id; S_AXI_ARADDR = addr; S_AXI_ARLEN = len;
        S_AXI_ARSIZE = size; S_AXI_ARBURST = burst; S_AXI_ARVALID = 1;
        n = 0;
        do begin @(negedge CLK); hs = S_AXI_ARREADY; @(posedge CLK); #1; n++; end while (!hs && n < 100);
        if (!hs) n_to++;
        S_AXI_ARVALID = 0;
        rd_n = 0; rd_lat = -1; rd_stall_bad = 0; done = 0; stalled = 0; held = 0; k = 1;
        while (!done && k < 200) begin
            if (rd_n == abort_at) begin
                RST = 1; S_AXI_RREADY = 0;
                return;
            end
            S_AXI_RREADY = (mode == 0) || (k % 4 == 1) || (k % 4 == 0);
            @(negedge CLK);
            if (S_AXI_RVALID && rd_lat < 0) rd_lat = k;
            if (stalled && (!S_AXI_RVALID || {S_AXI_RID, S_AXI_RLAST, S_AXI_RRESP, S_AXI_RDATA} != held))
                rd_stall_bad++;
            if (S_AXI_RVALID && S_AXI_RREADY) begin
                if (rd_n < 16) begin
                    rd_data[rd_n] = S_AXI_RDATA; rd_resp[rd_n] = S_AXI_RRESP; rd_last[rd_n] = S_AXI_RLAST;
                end
                rd_id = S_AXI_RID;
                rd_n++;
                done = S_AXI_RLAST;
            end
            stalled = S_AXI_RVALID && !S_AXI_RREADY;
            held = {S_AXI_RID, S_AXI_RLAST, S_AXI_RRESP, S_AXI_RDATA};
            @(posedge CLK); #1; k++;
        end
        if (!done) n_to++;
        S_AXI_RREADY = 0;
        @(negedge CLK);
        rd_extra = S_AXI_RVALID;
        @(posedge CLK); #1;
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_ready", 32'({S_AXI_AWREADY, S_AXI_ARREADY, S_AXI_WREADY}), 0);
        chk("rst_valid", 32'({S_AXI_BVALID, S_AXI_RVALID, S_AXI_RLAST}), 0);
        chk("rst_resp", 32'({S_AXI_BRESP, S_AXI_RRESP}), 0);
        chk("rst_ids", 32'({S_AXI_BID, S_AXI_RID}), 0);
        chk("rst_rdata", S_AXI_RDATA, 0);
        @(posedge CLK); #1;
        RST = 0;

        // AW and AR raised together: read must win, write follows
        S_AXI_AWID = 1; S_AXI_AWADDR = 32'h400; S_AXI_AWLEN = 0;
        S_AXI_AWSIZE = 3'b010; S_AXI_AWBURST = 2'b01; S_AXI_AWVALID = 1;
        rd(0, 32'h400, 0, 3'b010, 2'b01, 0, -1);
        chk("coll_rn", 32'(rd_n), 1);
        wr(1, 32'h400, 0, 3'b010, 2'b01, 32'hC0FFEE00, -1, -1);
        chk("coll_order", 32'(ar_t != 0 && ar_t < aw_t), 1);
        chk("coll_bid", 32'(b_id), 1);
        chk("coll_bresp", 32'(b_resp), 0);
        rd(1, 32'h400, 0, 3'b010, 2'b01, 0, -1);
        chk("coll_data", rd_data[0], 32'hC0FFEE00);
        chk("coll_rid", 32'(rd_id), 1);

        wr(0, 32'h100, 0, 3'b010, 2'b01, 32'hDEADBEEF, -1, -1);
        chk("single_bresp", 32'(b_resp), 0);
        chk("single_bid", 32'(b_id), 0);
        chk("single_bwait", 32'(b_wait), 0);
        rd(1, 32'h100, 0, 3'b010, 2'b01, 0, -1);
        chk("single_data", rd_data[0], 32'hDEADBEEF);
        chk("single_rresp", 32'(rd_resp[0]), 0);
        chk("single_rlast", 32'(rd_last[0]), 1);
        chk("single_lat", 32'(rd_lat), 2);
        chk("single_rid", 32'(rd_id), 1);

        wr(0, 32'h20C, 0, 3'b010, 2'b01, 32'hA5A5A5A5, -1, -1);
        wr(1, 32'h200, 15, 3'b010, 2'b01, 32'h0, 3, -1);
        chk("burst_bresp", 32'(b_resp), 0);
        rd(0, 32'h200, 15, 3'b010, 2'b01, 1, -1);
        chk("burst_n", 32'(rd_n), 16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("burst_d%0d", i), rd_data[i], (i == 3) ? 32'hA5A50003 : 32'(i));
            chk($sformatf("burst_l%0d", i), 32'(rd_last[i]), 32'(i == 15));
        end
        chk("burst_stable", 32'(rd_stall_bad), 0);
        chk("burst_extra", 32'(rd_extra), 0);

        wr(0, 32'h0000FFFC, 3, 3'b010, 2'b01, 32'h70, -1, -1);
        chk("wrap_bresp", 32'(b_resp), 0);
        rd(0, 32'h0, 2, 3'b010, 2'b01, 0, -1);
        for (int i = 0; i < 3; i++) chk($sformatf("wrap_d%0d", i), rd_data[i], 32'h71 + 32'(i));
        rd(0, 32'h0000FFFC, 0, 3'b010, 2'b01, 0, -1);
        chk("wrap_top", rd_data[0], 32'h70);

        wr(1, 32'h100, 0, 3'b001, 2'b01, 32'h12345678, -1, -1);
        chk("size_bresp", 32'(b_resp), 2);
        chk("size_bid", 32'(b_id), 1);
        rd(0, 32'h100, 0, 3'b010, 2'b01, 0, -1);
        chk("size_mem", rd_data[0], 32'hDEADBEEF);
        rd(1, 32'h200, 2, 3'b010, 2'b11, 0, -1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rsvd_resp%0d", i), 32'(rd_resp[i]), 2);
            chk($sformatf("rsvd_d%0d", i), rd_data[i], 0);
        end
        chk("rsvd_last", 32'(rd_last[2]), 1);

        wr(0, 32'h500, 3, 3'b010, 2'b01, 32'h55, -1, 1);
        chk("early_bresp", 32'(b_resp), 2);
        wr(0, 32'h510, 0, 3'b010, 2'b01, 32'h99, -1, -1);
        chk("after_err_bresp", 32'(b_resp), 0);

        rd(1, 32'h200, 7, 3'b010, 2'b01, 0, 5);
        @(posedge CLK); #1;
        chk("mid_rst_valid", 32'({S_AXI_RVALID, S_AXI_RLAST, S_AXI_BVALID}), 0);
        chk("mid_rst_ready", 32'({S_AXI_AWREADY, S_AXI_ARREADY, S_AXI_WREADY}), 0);
        chk("mid_rst_rdata", S_AXI_RDATA, 0);
        chk("mid_rst_rid", 32'(S_AXI_RID), 0);
        RST = 0;
        @(posedge CLK); #1;
        rd(0, 32'h100, 0, 3'b010, 2'b01, 0, -1);
        chk("post_rst_data", rd_data[0], 32'hDEADBEEF);
        chk("post_rst_last", 32'(rd_last[0]), 1);
        rd(0, 32'h208, 0, 3'b010, 2'b01, 0, -1);
        chk("post_rst_mem", rd_data[0], 32'h2);

        chk("timeouts", 32'(n_to), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
